sfu_csr_lane_splitter: RTL and testbench
========================================

Name: sfu_csr_lane_splitter

Overview:
- Upstream feeder of the SFU CSR unit.
- Accepts one full-width warp instruction (NUM_THREADS lanes of rs1 data plus thread mask).
- Issues it as a sequence of NUM_LANES-wide packets, each tagged with packet id (pid) and sop/eop.
- Skips packets whose thread-mask slice is empty; the CSR unit therefore only ever sees populated partial packets.

Parameters:
- NUM_THREADS, 4, threads per warp; power of two.
- NUM_LANES, 2, lanes per output packet; power of two, divides NUM_THREADS.
- XLEN, 32, data width per lane.
- META_W, 96, width of the opaque pass-through field (uuid, wid, PC, rd, wb, op_type, op_args).
- PID_W, max(1, log2(NUM_THREADS/NUM_LANES)), packet id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_meta  in  META_W  pass-through fields.
- in_tmask  in  NUM_THREADS  thread mask.
- in_rs1  in  NUM_THREADS*XLEN  rs1 data, lane i at bits [i*XLEN +: XLEN].
- out_valid  out  1  packet valid.
- out_ready  in  1  downstream accepts packet.
- out_meta  out  META_W  copy of in_meta.
- out_tmask  out  NUM_LANES  in_tmask slice for current pid.
- out_rs1  out  NUM_LANES*XLEN  rs1 slice for current pid.
- out_pid  out  PID_W  packet index, 0..NUM_THREADS/NUM_LANES-1.
- out_sop  out  1  first emitted packet of instruction.
- out_eop  out  1  last emitted packet of instruction.

Behaviour:
- P = NUM_THREADS/NUM_LANES packets; packet k covers threads k*NUM_LANES .. k*NUM_LANES+NUM_LANES-1.
- On in fire: register meta, tmask, rs1; set pid to the lowest non-empty packet; set sop=1; state IDLE->SPLIT.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - SPLIT: out_valid=1.
- SPLIT transitions:
  - out_valid && out_ready and more non-empty packets above pid: pid jumps to the next non-empty packet; sop=0. Empty packets are never emitted and cost no cycles.
  - Output fire on the last non-empty packet (eop=1): go to IDLE, unless a new instruction fires in the same cycle, then stay in SPLIT loaded with the new instruction (sop=1).
- in_ready = (state==IDLE) || (out_valid && out_ready && out_eop). This gives zero-bubble back-to-back instructions.
- out_eop is combinational from registered state: no non-empty packet above pid.
- All-zero in_tmask: exactly one packet, pid=0, tmask=0, sop=eop=1. The CSR side still sees the instruction and commits it.
- P==1: single packet, pid=0, sop=eop=1, still registered.
- Latency: input fire in cycle N -> first packet valid in cycle N+1. Outputs are fully registered; no combinational in->out path except in_ready depending on out_ready.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- Reset (reset==0 at a clock edge):
  - state=IDLE, out_valid=0, pid=0, sop=0, stored tmask=0.
  - out_eop reads 1 in IDLE but is don't-care while out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-SPLIT drops the in-flight instruction silently; no partial eop is produced.
- meta is never modified; rs1/tmask slices are pure selects by pid.

Test Plan (NUM_THREADS=4, NUM_LANES=2, XLEN=32):
- tmask=4'b1111, rs1={4,3,2,1}, out_ready=1 -> cycle N+1: pid0 tmask 2'b11 rs1{2,1} sop=1 eop=0; N+2: pid1 tmask 2'b11 rs1{4,3} sop=0 eop=1; in_ready high in N+2.
- tmask=4'b1100 -> single packet pid=1 tmask 2'b11 sop=eop=1; tmask=4'b0011 -> single packet pid=0 sop=eop=1.
- tmask=4'b0000 -> one packet pid=0 tmask=0 sop=eop=1.
- Back-to-back: two full-mask instructions, in_valid held, out_ready=1 -> 4 consecutive packets with no idle cycle; sop/eop pattern 10,01,10,01; meta switches exactly at the third packet.
- Backpressure: out_ready=0 for 3 cycles on pid0 -> outputs stable, in_ready=0; release -> pid1 next cycle.
- reset=0 asserted while pid0 pending -> next cycle out_valid=0, in_ready=1; a new instruction then starts with sop=1 and no stale packet appears.

Source files
------------

// File: rtl/sfu_csr_lane_splitter_if.sv
// Handshake bundle between the warp issue side and the SFU CSR unit:
// one full-width instruction in, NUM_LANES-wide packets out.
interface sfu_csr_lane_splitter_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int META_W      = 96
);
    localparam int P     = NUM_THREADS / NUM_LANES;
    localparam int PID_W = (P > 1) ? $clog2(P) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [META_W-1:0]           in_meta;
    logic [NUM_THREADS-1:0]      in_tmask;
    logic [NUM_THREADS*XLEN-1:0] in_rs1;

    logic                        out_valid;
    logic                        out_ready;
    logic [META_W-1:0]           out_meta;
    logic [NUM_LANES-1:0]        out_tmask;
    logic [NUM_LANES*XLEN-1:0]   out_rs1;
    logic [PID_W-1:0]            out_pid;
    logic                        out_sop;
    logic                        out_eop;

    modport master (
        output in_valid, in_meta, in_tmask, in_rs1, out_ready,
        input  in_ready, out_valid, out_meta, out_tmask, out_rs1, out_pid, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_meta, in_tmask, in_rs1, out_ready,
        output in_ready, out_valid, out_meta, out_tmask, out_rs1, out_pid, out_sop, out_eop
    );
endinterface

// File: rtl/sfu_csr_lane_splitter.sv
// Splits one warp-wide CSR instruction into NUM_LANES-wide packets, skipping
// packets whose thread-mask slice is empty. Outputs are fully registered.
module sfu_csr_lane_splitter #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int META_W      = 96
) (
    input logic                     clk,
    input logic                     reset,
    sfu_csr_lane_splitter_if.slave  bus
);
    localparam int P     = NUM_THREADS / NUM_LANES;
    localparam int PID_W = (P > 1) ? $clog2(P) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    state_e                      state_q;
    logic [META_W-1:0]           meta_q;
    logic [NUM_THREADS-1:0]      tmask_q;
    logic [NUM_THREADS*XLEN-1:0] rs1_q;
    logic [PID_W-1:0]            pid_q;
    logic                        sop_q;

    logic [P-1:0]                pkt_nz;
    logic [P-1:0]                in_nz;
    logic [PID_W-1:0]            first_pid;
    logic [PID_W-1:0]            next_pid;
    logic                        has_next;
    logic [NUM_LANES-1:0]        tmask_sel;
    logic [NUM_LANES*XLEN-1:0]   rs1_sel;
    logic                        out_fire;
    logic                        in_fire;
    logic                        in_ready;

    always_comb begin
        pkt_nz = '0;
        in_nz  = '0;
        for (int k = 0; k < P; k++) begin
            pkt_nz[k] = |tmask_q[k*NUM_LANES +: NUM_LANES];
            in_nz[k]  = |bus.in_tmask[k*NUM_LANES +: NUM_LANES];
        end
    end

    // Scan downward so the lowest qualifying packet index wins; an all-empty
    // incoming mask falls back to pid 0 so the instruction is still emitted.
    always_comb begin
        first_pid = '0;
        next_pid  = '0;
        has_next  = 1'b0;
        for (int k = P - 1; k >= 0; k--) begin
            if (in_nz[k]) begin
                first_pid = PID_W'(k);
            end
            if (pkt_nz[k] && (k > int'(pid_q))) begin
                has_next = 1'b1;
                next_pid = PID_W'(k);
            end
        end
    end

    always_comb begin
        tmask_sel = '0;
        rs1_sel   = '0;
        for (int k = 0; k < P; k++) begin
            if (pid_q == PID_W'(k)) begin
                tmask_sel = tmask_q[k*NUM_LANES +: NUM_LANES];
                rs1_sel   = rs1_q[k*NUM_LANES*XLEN +: NUM_LANES*XLEN];
            end
        end
    end

    assign out_fire = (state_q == SPLIT) && bus.out_ready;
    assign in_ready = (state_q == IDLE) || (out_fire && !has_next);
    assign in_fire  = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            tmask_q <= '0;
        end else if (in_fire) begin
            state_q <= SPLIT;
            pid_q   <= first_pid;
            sop_q   <= 1'b1;
            tmask_q <= bus.in_tmask;
        end else if (out_fire) begin
            if (has_next) begin
                pid_q <= next_pid;
                sop_q <= 1'b0;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    // NOTE: pure data registers carry no reset; they are only observed while
    // out_valid is high, which always follows a load on in_fire.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            meta_q <= bus.in_meta;
            rs1_q  <= bus.in_rs1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == SPLIT);
    assign bus.out_meta  = meta_q;
    assign bus.out_tmask = tmask_sel;
    assign bus.out_rs1   = rs1_sel;
    assign bus.out_pid   = pid_q;
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = !has_next;
endmodule

// File: tb/tb_sfu_csr_lane_splitter.sv
// Randomized bench for sfu_csr_lane_splitter: a queue of expected packets is
// built from each accepted instruction and compared against every output cycle.
module tb_sfu_csr_lane_splitter;
    localparam int NT    = 4;
    localparam int NL    = 2;
    localparam int XLEN  = 32;
    localparam int MW    = 96;
    localparam int P     = NT / NL;

    typedef struct {
        logic [MW-1:0]      meta;
        logic [NL-1:0]      tmask;
        logic [NL*XLEN-1:0] rs1;
        int                 pid;
        logic               sop;
        logic               eop;
    } pkt_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   out_fire_cnt = 0;
    logic last_in_fire = 1'b0;
    pkt_t exp_q[$];

    sfu_csr_lane_splitter_if #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XLEN), .META_W(MW)) bus ();

    sfu_csr_lane_splitter #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XLEN), .META_W(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand one accepted instruction into the packets the CSR side must see.
    task automatic model_accept(input logic [MW-1:0] m, input logic [NT-1:0] t,
                                input logic [NT*XLEN-1:0] r);
        int   last_k;
        bit   first;
        pkt_t p;
        last_k = -1;
        for (int k = 0; k < P; k++)
            if (t[k*NL +: NL] != '0) last_k = k;
        if (last_k < 0) begin
            p.meta = m; p.tmask = '0; p.rs1 = r[0 +: NL*XLEN];
            p.pid = 0; p.sop = 1'b1; p.eop = 1'b1;
            exp_q.push_back(p);
        end else begin
            first = 1'b1;
            for (int k = 0; k < P; k++) begin
                if (t[k*NL +: NL] != '0) begin
                    p.meta = m; p.tmask = t[k*NL +: NL]; p.rs1 = r[k*NL*XLEN +: NL*XLEN];
                    p.pid = k; p.sop = first; p.eop = (k == last_k);
                    exp_q.push_back(p);
                    first = 1'b0;
                end
            end
        end
    endtask

    // Monitor: sample mid-cycle, compare against the model, then advance it.
    always @(negedge clk) begin
        logic exp_rdy;
        last_in_fire = 1'b0;
        if (!reset) begin
            exp_q.delete();
        end else begin
            exp_rdy = (exp_q.size() == 0);
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                if (bus.out_ready && exp_q[0].eop) exp_rdy = 1'b1;
                check("meta",  bus.out_meta,  exp_q[0].meta);
                check("tmask", bus.out_tmask, exp_q[0].tmask);
                check("rs1",   bus.out_rs1,   exp_q[0].rs1);
                check("pid",   bus.out_pid,   exp_q[0].pid);
                check("sop",   bus.out_sop,   exp_q[0].sop);
                check("eop",   bus.out_eop,   exp_q[0].eop);
            end
            check("in_ready", bus.in_ready, exp_rdy);
            if (exp_q.size() != 0 && bus.out_ready) begin
                void'(exp_q.pop_front());
                out_fire_cnt++;
            end
            if (bus.in_valid && exp_rdy) begin
                model_accept(bus.in_meta, bus.in_tmask, bus.in_rs1);
                last_in_fire = 1'b1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MW-1:0] m, input logic [NT-1:0] t,
                        input logic [NT*XLEN-1:0] r);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_meta  = m;
        bus.in_tmask = t;
        bus.in_rs1   = r;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle();
            done = last_in_fire;
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", done, 1'b1);
    endtask

    function automatic logic [NT*XLEN-1:0] rs1_seq(input int base);
        logic [NT*XLEN-1:0] v;
        for (int i = 0; i < NT; i++) v[i*XLEN +: XLEN] = XLEN'(base + i + 1);
        return v;
    endfunction

    initial begin
        int   cnt0;
        logic pend;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_meta   = '0;
        bus.in_tmask  = '0;
        bus.in_rs1    = '0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_eop",   bus.out_eop, 1'b1);
        check("rst_pid",   bus.out_pid, 0);
        cycle();

        // Directed mask patterns: full, upper only, lower only, empty.
        send(96'hA1, 4'b1111, rs1_seq(0));
        repeat (3) cycle();
        send(96'hA2, 4'b1100, rs1_seq(10));
        repeat (2) cycle();
        send(96'hA3, 4'b0011, rs1_seq(20));
        repeat (2) cycle();
        send(96'hA4, 4'b0000, rs1_seq(30));
        repeat (2) cycle();

        // Back-to-back full-mask instructions with no idle cycle between them.
        cnt0 = out_fire_cnt;
        send(96'hB1, 4'b1111, rs1_seq(40));
        send(96'hB2, 4'b1111, rs1_seq(50));
        repeat (2) cycle();
        check("b2b_packets", out_fire_cnt - cnt0, 4);
        repeat (2) cycle();

        // Backpressure on pid0 for three cycles.
        bus.out_ready = 1'b0;
        cnt0 = out_fire_cnt;
        send(96'hC1, 4'b1111, rs1_seq(60));
        repeat (3) cycle();
        check("bp_hold", out_fire_cnt - cnt0, 0);
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        check("bp_release", out_fire_cnt - cnt0, 2);

        // Reset while pid0 is pending: nothing stale may appear afterwards.
        bus.out_ready = 1'b0;
        send(96'hD1, 4'b1111, rs1_seq(70));
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_valid", bus.out_valid, 1'b0);
        check("rst_mid_ready", bus.in_ready, 1'b1);
        cycle();
        send(96'hD2, 4'b0110, rs1_seq(80));
        repeat (3) cycle();

        // Randomized traffic with backpressure and occasional resets.
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                reset        = 1'b0;
                bus.in_valid = 1'b0;
                pend         = 1'b0;
            end else begin
                reset = 1'b1;
                if (!pend && $urandom_range(0, 2) == 0) begin
                    bus.in_meta  = {$urandom, $urandom, $urandom};
                    bus.in_tmask = ($urandom_range(0, 4) == 0) ? '0 : NT'($urandom);
                    bus.in_rs1   = {$urandom, $urandom, $urandom, $urandom};
                    bus.in_valid = 1'b1;
                    pend         = 1'b1;
                end
            end
            cycle();
            if (last_in_fire) begin
                bus.in_valid = 1'b0;
                pend         = 1'b0;
            end
        end

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2 * P + 2) cycle();
        check("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
